// File: rtl/blink_bcd_pkg.sv
// Shared types and seven-segment constants for the blink/BCD timer.
// Patterns are active-low, bit order gfedcba with bit 0 = segment a.
package blink_bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/blink_bcd_timer_seg7_dec.sv
// Single-digit BCD to active-low seven-segment decoder (purely combinational).
// Codes 10..15 decode to an all-off (blank) pattern.
module seg7_dec
  import blink_bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/blink_bcd_timer.sv
// Prescaled up/down BCD counter with blink output and seven-segment drive.
// Define BLINK_BCD_LEADING_BLANK_EN to blank leading zero digits.
module blink_bcd_timer
  import blink_bcd_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned BLINK_TICKS = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic                  UP,
  output logic                  GPIO0_D,
  output logic                  TICK,
  output logic                  WRAP,
  output logic [7*DIGITS-1:0]   nSEG
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  bcd_digit_t    digits     [DIGITS];
  bcd_digit_t    digits_nxt [DIGITS];
  logic          carry;
  logic          wrap_nxt;
  logic          term;
  logic          blink_term;
  logic [DIGITS-1:0] blank;

  assign term       = (presc == PW'(DIV - 1));
  assign blink_term = (blink_cnt == BW'(BLINK_TICKS - 1));

  // Ripple carry/borrow through the digits; a carry out of the top is a wrap.
  always_comb begin
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      digits_nxt[k] = digits[k];
      if (carry) begin
        if (UP) begin
          if (digits[k] >= 4'd9) begin
            digits_nxt[k] = 4'd0;
          end else begin
            digits_nxt[k] = digits[k] + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          if (digits[k] == 4'd0) begin
            digits_nxt[k] = 4'd9;
          end else begin
            digits_nxt[k] = digits[k] - 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
    wrap_nxt = carry;
  end

  // CLR outranks EN and terminal count; the blink divider is reset-only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc     <= '0;
      blink_cnt <= '0;
      GPIO0_D   <= 1'b0;
      TICK      <= 1'b0;
      WRAP      <= 1'b0;
      for (int k = 0; k < DIGITS; k++) digits[k] <= '0;
    end else if (CLR) begin
      presc <= '0;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
      for (int k = 0; k < DIGITS; k++) digits[k] <= '0;
    end else begin
      TICK <= 1'b0;
      WRAP <= 1'b0;
      if (EN) begin
        if (term) begin
          presc <= '0;
          TICK  <= 1'b1;
          WRAP  <= wrap_nxt;
          for (int k = 0; k < DIGITS; k++) digits[k] <= digits_nxt[k];
          if (blink_term) begin
            blink_cnt <= '0;
            GPIO0_D   <= ~GPIO0_D;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

`ifdef BLINK_BCD_LEADING_BLANK_EN
  logic seen_nz;

  // Blank zeros above the highest non-zero digit; digit 0 always shows.
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      if (digits[k] != 4'd0) seen_nz = 1'b1;
      blank[k] = ~seen_nz;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [6:0] seg_c;

    seg7_dec u_dec (
      .bcd   (digits[k]),
      .seg_c (seg_c)
    );

    assign nSEG[7*k +: 7] = blank[k] ? SEG_BLANK : seg_c;
  end

endmodule

// File: tb/tb_blink_bcd_timer.sv
// Directed bench for blink_bcd_timer at CLK_HZ=10, TICK_HZ=1, DIGITS=4, BLINK_TICKS=2.
// Expected display follows BLINK_BCD_LEADING_BLANK_EN when defined.
module tb_blink_bcd_timer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN  = 1'b0;
  logic        CLR = 1'b0;
  logic        UP  = 1'b1;
  logic        GPIO0_D;
  logic        TICK;
  logic        WRAP;
  logic [27:0] nSEG;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt   = 0;
  int ticks = 0;

  typedef struct {
    logic up;
    int   value;
    logic wrap;
  } vec_t;

  vec_t vecs [8];

  always #5 CLK = ~CLK;

  blink_bcd_timer #(
    .CLK_HZ      (10),
    .TICK_HZ     (1),
    .DIGITS      (4),
    .BLINK_TICKS (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .CLR     (CLR),
    .UP      (UP),
    .GPIO0_D (GPIO0_D),
    .TICK    (TICK),
    .WRAP    (WRAP),
    .nSEG    (nSEG)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] exp_seg(input int v);
    logic [27:0] r;
    int d [4];
    int p;
    bit seen;
    p    = v;
    seen = 1'b0;
    r    = '0;
    for (int i = 0; i < 4; i++) begin
      d[i] = p % 10;
      p    = p / 10;
    end
    for (int i = 3; i >= 0; i--) begin
      if (d[i] != 0) seen = 1'b1;
      r[7*i +: 7] = seg_of(d[i]);
`ifdef BLINK_BCD_LEADING_BLANK_EN
      if (!seen && i != 0) r[7*i +: 7] = 7'h7F;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait for TICK at negedges; gap is the number of negedges consumed.
  task automatic wait_tick(input string name, input int exp_gap);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (TICK !== 1'b1 && n < 200);
    check({name, "_gap"}, 32'(n), 32'(exp_gap));
    if (TICK === 1'b1) ticks++;
  endtask

  task automatic check_tick_outputs(input string name, input logic exp_wrap);
    check({name, "_nseg"}, 32'(nSEG), 32'(exp_seg(cnt)));
    check({name, "_wrap"}, 32'(WRAP), 32'(exp_wrap));
    check({name, "_gpio"}, 32'(GPIO0_D), 32'((ticks / 2) % 2));
  endtask

  // TICK and WRAP must be single-cycle pulses.
  task automatic check_after_tick(input string name);
    @(negedge CLK);
    check({name, "_tick_low"}, 32'(TICK), 32'd0);
    check({name, "_wrap_low"}, 32'(WRAP), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    vecs[0] = '{1'b1,    2, 1'b0};
    vecs[1] = '{1'b0,    1, 1'b0};
    vecs[2] = '{1'b0,    0, 1'b0};
    vecs[3] = '{1'b0, 9999, 1'b1};
    vecs[4] = '{1'b0, 9998, 1'b0};
    vecs[5] = '{1'b1, 9999, 1'b0};
    vecs[6] = '{1'b1,    0, 1'b1};
    vecs[7] = '{1'b1,    1, 1'b0};

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("rst_tick", 32'(TICK), 32'd0);
      check("rst_wrap", 32'(WRAP), 32'd0);
      check("rst_gpio", 32'(GPIO0_D), 32'd0);
      check("rst_nseg", 32'(nSEG), 32'(exp_seg(0)));
    end
    RST = 1'b0;
    EN  = 1'b1;
    check("pre_first_digit0", 32'(nSEG[6:0]), 32'h40);
    wait_tick("first", 10);
    cnt = 1;
    check("first_digit0", 32'(nSEG[6:0]), 32'h79);
    check_tick_outputs("first", 1'b0);
    check_after_tick("first");

    // Table of tick steps covering direction changes and both wraps
    foreach (vecs[i]) begin
      UP = vecs[i].up;
      wait_tick($sformatf("vec%0d", i), 9);
      cnt = vecs[i].value;
      check_tick_outputs($sformatf("vec%0d", i), vecs[i].wrap);
      check_after_tick($sformatf("vec%0d", i));
    end

    // CLR while prescaler sits at terminal count
    idle(8);
    CLR = 1'b1;
    @(negedge CLK);
    cnt = 0;
    check("clr_tick", 32'(TICK), 32'd0);
    check("clr_wrap", 32'(WRAP), 32'd0);
    check("clr_nseg", 32'(nSEG), 32'(exp_seg(0)));
    check("clr_gpio", 32'(GPIO0_D), 32'((ticks / 2) % 2));
    CLR = 1'b0;
    wait_tick("after_clr", 10);
    cnt = 1;
    check_tick_outputs("after_clr", 1'b0);
    check_after_tick("after_clr");

    // EN low for 7 cycles mid-count
    idle(3);
    EN = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      if (TICK === 1'b1) check("freeze_tick", 32'(TICK), 32'd0);
    end
    check("freeze_gpio", 32'(GPIO0_D), 32'((ticks / 2) % 2));
    check("freeze_nseg", 32'(nSEG), 32'(exp_seg(cnt)));
    EN = 1'b1;
    wait_tick("after_freeze", 6);
    cnt = 2;
    check_tick_outputs("after_freeze", 1'b0);
    check_after_tick("after_freeze");

    // RST mid-count abandons the count and the blink divider
    idle(4);
    RST = 1'b1;
    @(negedge CLK);
    cnt   = 0;
    ticks = 0;
    check("midrst_nseg", 32'(nSEG), 32'(exp_seg(0)));
    check("midrst_gpio", 32'(GPIO0_D), 32'd0);
    check("midrst_tick", 32'(TICK), 32'd0);
    RST = 1'b0;
    wait_tick("after_rst", 10);
    cnt = 1;
    check_tick_outputs("after_rst", 1'b0);
    check_after_tick("after_rst");

    // Step up to 0105, checking the display decode at every tick
    UP = 1'b1;
    for (int i = 0; i < 104; i++) begin
      wait_tick("step", 9);
      cnt++;
      check_tick_outputs($sformatf("step%0d", cnt), 1'b0);
      @(negedge CLK);
    end
`ifdef BLINK_BCD_LEADING_BLANK_EN
    check("d3_0105", 32'(nSEG[27:21]), 32'h7F);
`else
    check("d3_0105", 32'(nSEG[27:21]), 32'h40);
`endif
    check("d2_0105", 32'(nSEG[20:14]), 32'h79);
    check("d1_0105", 32'(nSEG[13:7]),  32'h40);
    check("d0_0105", 32'(nSEG[6:0]),   32'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
